sevseg_scan_ctrl: RTL and testbench

Memory-mapped controller that time-multiplexes the 4-digit seven-segment display: it holds display state in registers and scans digits with a programmable dwell and anti-ghosting blank interval. It sits between the core's peripheral bus and the SEVSEG segment/select pins. It supports hex-decode mode and raw-segment mode, plus a per-digit enable mask.

---
 rtl/sevseg_bus_if.sv | 20 ++
 rtl/sevseg_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sevseg_bus_if.sv
// Register bus between the core and the seven-segment scan controller.
// Single-cycle write strobe; reads answer one cycle later with rd_valid.
interface sevseg_bus_if;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;

  modport master (
    output wr_en, rd_en, addr, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// 4-digit seven-segment scan controller.
// Register-mapped display state, dwell/blank scan FSM, registered pins.
module sevseg_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sevseg_bus_if.slave  bus,
  output logic [6:0]   segments,
  output logic [3:0]   select
);

  localparam int unsigned CMAX =
    (DIGIT_CYCLES > BLANK_CYCLES) ?
    DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned BL =
    (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [CW-1:0] DLAST =
    CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLAST = CW'(BL);
  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] SEL_OFF =
    SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {
    SHOW,
    BLANK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   value_q, value_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [15:0]   raw01_q, raw01_d;
  logic [15:0]   raw23_q, raw23_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;

  logic [15:0]   rd_word;
  logic [3:0]    nib;
  logic [6:0]    raw_fld;
  logic [6:0]    seg_on;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan sequencing
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == DLAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            digit_d = digit_q + 2'd1;
          end else begin
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          digit_d = digit_q + 2'd1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    raw01_d = raw01_q;
    raw23_d = raw23_q;
    if (bus.wr_en) begin
      case (bus.addr)
        2'd0: value_d = bus.wr_data;
        2'd1: ctrl_d  = bus.wr_data[4:0];
        2'd2: raw01_d = bus.wr_data & 16'h7F7F;
        default:
          raw23_d = bus.wr_data & 16'h7F7F;
      endcase
    end
  end

  always_comb begin
    case (bus.addr)
      2'd0:    rd_word = value_q;
      2'd1:    rd_word = {11'd0, ctrl_q};
      2'd2:    rd_word = raw01_q;
      default: rd_word = raw23_q;
    endcase
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? rd_word : rd_data_q;
  end

  always_comb begin
    nib = value_q[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd0:    raw_fld = raw01_q[6:0];
      2'd1:    raw_fld = raw01_q[14:8];
      2'd2:    raw_fld = raw23_q[6:0];
      default: raw_fld = raw23_q[14:8];
    endcase
    seg_on = ctrl_q[4] ? raw_fld : hex7(nib);
    seg_d  = SEG_OFF;
    sel_d  = SEL_OFF;
    // Masked digits still burn their slot
    if (state_q == SHOW && ctrl_q[digit_q]) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      sel_d = 4'b0001 << digit_q;
      if (SEL_ACTIVE_LOW) sel_d = ~sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SHOW;
      digit_q    <= 2'd0;
      cnt_q      <= '0;
      value_q    <= 16'h0000;
      ctrl_q     <= 5'h0F;
      raw01_q    <= 16'h0000;
      raw23_q    <= 16'h0000;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
      seg_q      <= SEG_OFF;
      sel_q      <= SEL_OFF;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      ctrl_q     <= ctrl_d;
      raw01_q    <= raw01_d;
      raw23_q    <= raw23_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign segments     = seg_q;
  assign select       = sel_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboard bench: two scan configs (blank=1, blank=0) share one bus.
// Stimulus queues expected pins/reads; a monitor pops and compares.
module tb_sevseg_scan_ctrl;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
    logic       rv;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] seg_a, seg_b;
  logic [3:0] sel_a, sel_b;

  sevseg_bus_if ifc_a ();
  sevseg_bus_if ifc_b ();

  sevseg_scan_ctrl #(
    .DIGIT_CYCLES   (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc_a),
    .segments (seg_a),
    .select   (sel_a)
  );

  sevseg_scan_ctrl #(
    .DIGIT_CYCLES   (4),
    .BLANK_CYCLES   (0),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc_b),
    .segments (seg_b),
    .select   (sel_b)
  );

  always #5 clk = ~clk;

  out_t        qa[$], qb[$];
  logic [15:0] rqa[$], rqb[$];
  int          nvec  = 0;
  int          nfail = 0;

  // reference register image, hand masks
  logic [15:0] m_value, m_ctrl, m_raw01, m_raw23;
  int          pos;

  function automatic logic [6:0] hexseg(
    input logic [3:0] n
  );
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
          7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C,
          7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic out_t exp_out(
    input int   p,
    input int   bc,
    input logic rv
  );
    int per;
    int q;
    int d;
    int s;
    logic [6:0] on;
    logic [3:0] one;
    out_t o;
    per = 4 + bc;
    q = p % (4 * per);
    d = q / per;
    s = q % per;
    o.seg = 7'h7F;
    o.sel = 4'hF;
    o.rv  = rv;
    if (s < 4 && m_ctrl[d]) begin
      if (m_ctrl[4]) begin
        case (d)
          0: on = m_raw01[6:0];
          1: on = m_raw01[14:8];
          2: on = m_raw23[6:0];
          default: on = m_raw23[14:8];
        endcase
      end else begin
        on = hexseg(m_value[d*4 +: 4]);
      end
      one = 4'b0001;
      o.seg = ~on;
      o.sel = ~(one << d);
    end
    return o;
  endfunction

  function automatic logic [15:0] m_read(
    input logic [1:0] a
  );
    case (a)
      2'd0: return m_value;
      2'd1: return m_ctrl;
      2'd2: return m_raw01;
      default: return m_raw23;
    endcase
  endfunction

  task automatic chk(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] req
  );
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic step(
    input logic        r,
    input logic        w,
    input logic        rd,
    input logic [1:0]  a,
    input logic [15:0] d
  );
    out_t off;
    off.seg = 7'h7F;
    off.sel = 4'hF;
    off.rv  = 1'b0;
    rst = r;
    ifc_a.wr_en = w;  ifc_b.wr_en = w;
    ifc_a.rd_en = rd; ifc_b.rd_en = rd;
    ifc_a.addr = a;   ifc_b.addr = a;
    ifc_a.wr_data = d; ifc_b.wr_data = d;
    if (r) begin
      qa.push_back(off);
      qb.push_back(off);
      m_value = 16'h0000;
      m_ctrl  = 16'h000F;
      m_raw01 = 16'h0000;
      m_raw23 = 16'h0000;
      pos = 0;
    end else begin
      qa.push_back(exp_out(pos, 1, rd));
      qb.push_back(exp_out(pos, 0, rd));
      if (rd) begin
        rqa.push_back(m_read(a));
        rqb.push_back(m_read(a));
      end
      if (w) begin
        case (a)
          2'd0: m_value = d;
          2'd1: m_ctrl  = d & 16'h001F;
          2'd2: m_raw01 = d & 16'h7F7F;
          default: m_raw23 = d & 16'h7F7F;
        endcase
      end
      pos++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic wr(
    input logic [1:0] a,
    input logic [15:0] d
  );
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, 1'b0, 1'b1, a, 16'h0);
  endtask

  // Monitor: one pin vector per edge, reads on rd_valid
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      out_t e;
      e = qa.pop_front();
      chk("pins_a", {4'd0, seg_a, sel_a,
          ifc_a.rd_valid},
          {4'd0, e.seg, e.sel, e.rv});
    end
    if (qb.size() > 0) begin
      out_t e;
      e = qb.pop_front();
      chk("pins_b", {4'd0, seg_b, sel_b,
          ifc_b.rd_valid},
          {4'd0, e.seg, e.sel, e.rv});
    end
    if (ifc_a.rd_valid) begin
      if (rqa.size() == 0)
        chk("rd_a_extra", 16'h1, 16'h0);
      else
        chk("rd_a", ifc_a.rd_data,
            rqa.pop_front());
    end
    if (ifc_b.rd_valid) begin
      if (rqb.size() == 0)
        chk("rd_b_extra", 16'h1, 16'h0);
      else
        chk("rd_b", ifc_b.rd_data,
            rqb.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("rst_rd_data_a", ifc_a.rd_data, 16'h0);
    chk("rst_rd_data_b", ifc_b.rd_data, 16'h0);
    // hex scan
    wr(2'd0, 16'h1234);
    idle(25);
    // mask digits 1 and 3 off
    wr(2'd1, 16'h0005);
    idle(22);
    // raw mode then back to hex mid-scan
    wr(2'd2, 16'h4940);
    wr(2'd1, 16'h001F);
    idle(22);
    wr(2'd1, 16'h000F);
    idle(10);
    // readback and masking of unused bits
    wr(2'd1, 16'hFFFF);
    rd(2'd1);
    idle(1);
    wr(2'd3, 16'hFFFF);
    rd(2'd3);
    rd(2'd2);
    step(1'b0, 1'b1, 1'b1, 2'd0, 16'hABCD);
    rd(2'd0);
    wr(2'd1, 16'h000F);
    idle(3);
    // reset in the middle of digit 2
    while ((pos % 20) != 11) idle(1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd3);
    idle(8);
    @(posedge clk);
    #3;
    chk("drain_a", 16'(qa.size() + rqa.size()),
        16'h0);
    chk("drain_b", 16'(qb.size() + rqb.size()),
        16'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
